// File: rtl/dn_bus_arbiter_pkg.sv
// Shared types and default sizing for the ladybug download-port arbiter.
package ladybug_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_RST_HOLD = 256;
    localparam int DEF_IOCTL_AW = 25;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        HOLD,
        DL,
        RUN,
        HS
    } arb_state_t;

endpackage

// File: rtl/dn_bus_arbiter_if.sv
// Download-port bus: ioctl and hiscore requesters in, granted write port out.
// slave is the arbiter's view; master is the requester/core side.
interface dn_bus_arbiter_if
    import ladybug_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int IOCTL_AW = DEF_IOCTL_AW
);

    logic                ioctl_download;
    logic                ioctl_wr;
    logic [IOCTL_AW-1:0] ioctl_addr;
    logic [7:0]          ioctl_dout;

    logic                hs_req;
    logic [ADDR_W-1:0]   hs_addr;
    logic [7:0]          hs_data;
    logic                hs_wr;
    logic                hs_gnt;

    logic [ADDR_W-1:0]   dn_addr;
    logic [7:0]          dn_data;
    logic                dn_wr;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  hs_req, hs_addr, hs_data, hs_wr,
        output hs_gnt,
        output dn_addr, dn_data, dn_wr
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output hs_req, hs_addr, hs_data, hs_wr,
        input  hs_gnt,
        input  dn_addr, dn_data, dn_wr
    );

endinterface

// File: rtl/dn_bus_arbiter_reset_stretch.sv
// Settle-window counter: counts enabled cycles and flags the last one of RST_HOLD.
module reset_stretch
    import ladybug_pkg::*;
#(
    parameter int RST_HOLD = DEF_RST_HOLD
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RST_HOLD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = en && (cnt == LAST);

endmodule

// File: rtl/dn_bus_arbiter.sv
// Shares the core download write port between HPS ioctl and the hiscore engine,
// and sequences core reset / pause around those transfers.
module dn_bus_arbiter
    import ladybug_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RST_HOLD = DEF_RST_HOLD,
    parameter int IOCTL_AW = DEF_IOCTL_AW
) (
    input  logic             clk_sys,
    input  logic             reset,
    dn_bus_arbiter_if.slave  bus,
    output logic             core_reset,
    output logic             core_pause,
    output logic             addr_ovf
);

    arb_state_t state;
    logic       hold_done;
    logic       ioctl_in_range;

    assign ioctl_in_range = (bus.ioctl_addr[IOCTL_AW-1:ADDR_W] == '0);

    // Counter only runs in HOLD; it is zeroed everywhere else and on a new download.
    reset_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_reset_stretch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .en      (state == HOLD),
        .clr     ((state != HOLD) || bus.ioctl_download),
        .done    (hold_done)
    );

    // Outputs are updated on the same edge as the state change they belong to.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= HOLD;
            core_reset  <= 1'b1;
            core_pause  <= 1'b0;
            addr_ovf    <= 1'b0;
            bus.hs_gnt  <= 1'b0;
            bus.dn_wr   <= 1'b0;
            bus.dn_addr <= '0;
            bus.dn_data <= '0;
        end else begin
            bus.dn_wr <= 1'b0;
            unique case (state)
                HOLD: begin
                    if (bus.ioctl_download) begin
                        state    <= DL;
                        addr_ovf <= 1'b0;
                    end else if (hold_done) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end
                end
                DL: begin
                    if (bus.ioctl_wr) begin
                        if (ioctl_in_range) begin
                            bus.dn_wr   <= 1'b1;
                            bus.dn_addr <= bus.ioctl_addr[ADDR_W-1:0];
                            bus.dn_data <= bus.ioctl_dout;
                        end else begin
                            addr_ovf <= 1'b1;
                        end
                    end
                    if (!bus.ioctl_download) begin
                        state <= HOLD;
                    end
                end
                RUN: begin
                    if (bus.ioctl_download) begin
                        state      <= DL;
                        core_reset <= 1'b1;
                        addr_ovf   <= 1'b0;
                    end else if (bus.hs_req) begin
                        state      <= HS;
                        bus.hs_gnt <= 1'b1;
                        core_pause <= 1'b1;
                    end
                end
                HS: begin
                    // A download pre-empts the hiscore engine and drops its pending write.
                    if (bus.ioctl_download) begin
                        state      <= DL;
                        core_reset <= 1'b1;
                        addr_ovf   <= 1'b0;
                        bus.hs_gnt <= 1'b0;
                        core_pause <= 1'b0;
                    end else begin
                        if (bus.hs_wr) begin
                            bus.dn_wr   <= 1'b1;
                            bus.dn_addr <= bus.hs_addr;
                            bus.dn_data <= bus.hs_data;
                        end
                        if (!bus.hs_req) begin
                            state      <= RUN;
                            bus.hs_gnt <= 1'b0;
                            core_pause <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= HOLD;
                    core_reset <= 1'b1;
                    core_pause <= 1'b0;
                    bus.hs_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dn_bus_arbiter.sv
// Self-checking bench for dn_bus_arbiter: vector table, corner sequences, random run vs. model.
module tb_dn_bus_arbiter;
    import ladybug_pkg::*;

    localparam int AW  = 16;
    localparam int IAW = 25;
    localparam int RH  = 256;

    logic clk_sys = 1'b0;
    logic reset;
    logic core_reset, core_pause, addr_ovf;

    dn_bus_arbiter_if #(.ADDR_W(AW), .IOCTL_AW(IAW)) bus ();

    dn_bus_arbiter #(
        .ADDR_W   (AW),
        .RST_HOLD (RH),
        .IOCTL_AW (IAW)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus),
        .core_reset (core_reset),
        .core_pause (core_pause),
        .addr_ovf   (addr_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    // Reference model: download flag, remaining settle cycles, hiscore ownership.
    bit          m_dl, m_hs, m_ovf, m_wr;
    int          m_settle;
    logic [AW-1:0] m_addr;
    logic [7:0]  m_data;
    bit          mchk = 1'b0;
    bit          saw_wr;

    typedef struct {
        bit           dl;
        bit           iwr;
        logic [IAW-1:0] iaddr;
        logic [7:0]   idata;
        bit           ewr;
        logic [AW-1:0] eaddr;
        logic [7:0]   edata;
        bit           ecr;
        bit           eovf;
        bit           settle;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_dl = 0; m_hs = 0; m_ovf = 0; m_wr = 0;
            m_addr = '0; m_data = '0; m_settle = RH;
        end else begin
            m_wr = 0;
            if (m_dl) begin
                if (bus.ioctl_wr) begin
                    if ((bus.ioctl_addr >> AW) == 0) begin
                        m_wr = 1; m_addr = bus.ioctl_addr[AW-1:0]; m_data = bus.ioctl_dout;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (!bus.ioctl_download) begin
                    m_dl = 0; m_settle = RH;
                end
            end else if (bus.ioctl_download) begin
                m_dl = 1; m_hs = 0; m_ovf = 0; m_settle = 0;
            end else if (m_settle > 0) begin
                m_settle--;
            end else if (m_hs) begin
                if (bus.hs_wr) begin
                    m_wr = 1; m_addr = bus.hs_addr; m_data = bus.hs_data;
                end
                if (!bus.hs_req) m_hs = 0;
            end else if (bus.hs_req) begin
                m_hs = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        if (bus.dn_wr === 1'b1) saw_wr = 1'b1;
        if (mchk) begin
            chk("model_core_reset", 32'(core_reset), 32'(m_dl || (m_settle > 0)));
            chk("model_hs_gnt",     32'(bus.hs_gnt), 32'(m_hs));
            chk("model_core_pause", 32'(core_pause), 32'(m_hs));
            chk("model_dn_wr",      32'(bus.dn_wr),  32'(m_wr));
            chk("model_dn_addr",    32'(bus.dn_addr), 32'(m_addr));
            chk("model_dn_data",    32'(bus.dn_data), 32'(m_data));
            chk("model_addr_ovf",   32'(addr_ovf),   32'(m_ovf));
        end
    endtask

    // Counts cycles core_reset stays high, including the current one.
    task automatic measure_settle(input string name);
        int n = 0;
        while (core_reset === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        chk(name, 32'(n), 32'(RH));
    endtask

    task automatic clear_inputs();
        bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        bus.hs_req = 0; bus.hs_wr = 0; bus.hs_addr = '0; bus.hs_data = '0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 25'h0000000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 25'h0000000, 8'hA5, 1'b1, 16'h0000, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 25'h0000001, 8'h5A, 1'b1, 16'h0001, 8'h5A, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 25'h0000002, 8'hFF, 1'b1, 16'h0002, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 25'h0000003, 8'h00, 1'b1, 16'h0003, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 25'h0000000, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 25'h0000000, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 25'h0000000, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 25'h0010000, 8'h77, 1'b0, 16'h0003, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 25'h0000000, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 25'h0000000, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 25'h000FFFF, 8'hC3, 1'b1, 16'hFFFF, 8'hC3, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 25'h0000000, 8'h00, 1'b0, 16'hFFFF, 8'hC3, 1'b1, 1'b0, 1'b1};

        clear_inputs();
        reset = 1'b1;
        mchk  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_hs_gnt",     32'(bus.hs_gnt), 32'd0);
        chk("rst_core_pause", 32'(core_pause), 32'd0);
        chk("rst_dn_wr",      32'(bus.dn_wr),  32'd0);
        chk("rst_dn_addr",    32'(bus.dn_addr), 32'd0);
        chk("rst_dn_data",    32'(bus.dn_data), 32'd0);
        chk("rst_addr_ovf",   32'(addr_ovf),   32'd0);

        reset  = 1'b0;
        saw_wr = 1'b0;
        measure_settle("powerup_hold_len");
        chk("powerup_no_dn_wr", 32'(saw_wr), 32'd0);

        // Download, overflow and settle restart vectors, starting from RUN.
        for (int i = 0; i < 13; i++) begin
            bus.ioctl_download = tbl[i].dl;
            bus.ioctl_wr       = tbl[i].iwr;
            bus.ioctl_addr     = tbl[i].iaddr;
            bus.ioctl_dout     = tbl[i].idata;
            tick();
            chk($sformatf("vec%0d_dn_wr", i),      32'(bus.dn_wr),   32'(tbl[i].ewr));
            chk($sformatf("vec%0d_dn_addr", i),    32'(bus.dn_addr), 32'(tbl[i].eaddr));
            chk($sformatf("vec%0d_dn_data", i),    32'(bus.dn_data), 32'(tbl[i].edata));
            chk($sformatf("vec%0d_core_reset", i), 32'(core_reset),  32'(tbl[i].ecr));
            chk($sformatf("vec%0d_addr_ovf", i),   32'(addr_ovf),    32'(tbl[i].eovf));
            chk($sformatf("vec%0d_hs_gnt", i),     32'(bus.hs_gnt),  32'd0);
            if (tbl[i].settle) measure_settle($sformatf("vec%0d_settle_len", i));
        end
        clear_inputs();

        // Strobes from the wrong source in RUN are ignored.
        bus.hs_wr = 1; bus.hs_addr = 16'h4444; bus.hs_data = 8'h44;
        bus.ioctl_wr = 1; bus.ioctl_addr = 25'h5; bus.ioctl_dout = 8'h55;
        tick();
        chk("run_ignore_wr", 32'(bus.dn_wr), 32'd0);
        clear_inputs();

        // Hiscore grant, write, release.
        bus.hs_req = 1;
        tick();
        chk("hs_gnt_on",    32'(bus.hs_gnt), 32'd1);
        chk("hs_pause_on",  32'(core_pause), 32'd1);
        chk("hs_core_rst0", 32'(core_reset), 32'd0);
        bus.hs_wr = 1; bus.hs_addr = 16'h6000; bus.hs_data = 8'h12;
        tick();
        chk("hs_wr_pulse", 32'(bus.dn_wr),   32'd1);
        chk("hs_wr_addr",  32'(bus.dn_addr), 32'h6000);
        chk("hs_wr_data",  32'(bus.dn_data), 32'h12);
        bus.hs_wr = 0;
        tick();
        chk("hs_wr_single", 32'(bus.dn_wr),   32'd0);
        chk("hs_addr_hold", 32'(bus.dn_addr), 32'h6000);
        bus.hs_req = 0;
        tick();
        chk("hs_gnt_off",   32'(bus.hs_gnt), 32'd0);
        chk("hs_pause_off", 32'(core_pause), 32'd0);
        chk("hs_core_rst1", 32'(core_reset), 32'd0);

        // Pre-emption of a granted hiscore engine by a download.
        bus.hs_req = 1;
        tick();
        chk("pre_gnt", 32'(bus.hs_gnt), 32'd1);
        bus.ioctl_download = 1; bus.hs_wr = 1; bus.hs_addr = 16'h1234; bus.hs_data = 8'h99;
        tick();
        chk("pre_no_wr",     32'(bus.dn_wr),   32'd0);
        chk("pre_addr_hold", 32'(bus.dn_addr), 32'h6000);
        chk("pre_gnt_off",   32'(bus.hs_gnt),  32'd0);
        chk("pre_pause_off", 32'(core_pause),  32'd0);
        chk("pre_core_rst",  32'(core_reset),  32'd1);
        clear_inputs();
        tick();
        measure_settle("pre_settle_len");

        // Download and hiscore request rising together: download wins, grant waits.
        bus.hs_req = 1; bus.ioctl_download = 1;
        tick();
        chk("sim_gnt0",     32'(bus.hs_gnt), 32'd0);
        chk("sim_core_rst", 32'(core_reset), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sim_dl_gnt%0d", i), 32'(bus.hs_gnt), 32'd0);
        end
        bus.ioctl_download = 0;
        tick();
        begin
            int n = 0;
            while (core_reset === 1'b1 && n < 2000) begin
                n++;
                tick();
            end
            chk("sim_hold_len", 32'(n), 32'(RH));
        end
        chk("sim_run_entry_gnt", 32'(bus.hs_gnt), 32'd0);
        tick();
        chk("sim_gnt_after_run", 32'(bus.hs_gnt), 32'd1);
        chk("sim_pause",         32'(core_pause), 32'd1);
        clear_inputs();
        tick();

        // Randomised traffic against the model.
        for (int c = 0; c < 15000; c++) begin
            reset = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0) bus.ioctl_download = ~bus.ioctl_download;
            if ($urandom_range(0, 24) == 0)  bus.hs_req = ~bus.hs_req;
            bus.ioctl_wr   = $urandom_range(0, 1) == 1;
            bus.ioctl_addr = IAW'($urandom);
            if ($urandom_range(0, 7) != 0) bus.ioctl_addr[IAW-1:AW] = '0;
            bus.ioctl_dout = 8'($urandom);
            bus.hs_wr      = $urandom_range(0, 1) == 1;
            bus.hs_addr    = AW'($urandom);
            bus.hs_data    = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
